// File: rtl/mult_lut_arbiter_if.sv
// Purpose: requester-side bundle for the shared signed multiplier (requests, operands, grant, result).
// Latency: none, wires only.
// Backpressure: a requester holds REQ and operands until it sees its GNT bit.
interface mult_lut_arbiter_if #(
    parameter int MUT_WIDTH = 6,
    parameter int NUM_REQ   = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           REQ;
    logic [NUM_REQ*MUT_WIDTH-1:0] DATA_A;
    logic [NUM_REQ*MUT_WIDTH-1:0] DATA_B;
    logic [NUM_REQ-1:0]           GNT;
    logic                         BUSY;
    logic [2*MUT_WIDTH-1:0]       DATA_Q;
    logic [ID_W-1:0]              Q_ID;
    logic                         DONE;

    // Requesters drive requests/operands and observe grant/result.
    modport master (
        output REQ, DATA_A, DATA_B,
        input  GNT, BUSY, DATA_Q, Q_ID, DONE
    );

    // The arbiter consumes requests/operands and drives grant/result.
    modport slave (
        input  REQ, DATA_A, DATA_B,
        output GNT, BUSY, DATA_Q, Q_ID, DONE
    );
endinterface

// File: rtl/mult_lut_arbiter.sv
// Purpose: round-robin share of one combinational signed multiplier LUT among NUM_REQ requesters.
// Latency: grant on the sampling edge, DONE/DATA_Q CALC_CYCLES edges later; one result per 1+CALC_CYCLES cycles.
// Backpressure: none queued; a request is just a held REQ level, ignored while BUSY.

// Combinational signed A*B, full 2W-bit product.
module mult_lut_signed #(
    parameter int W = 6
) (
    input  logic signed [W-1:0]   a_i,
    input  logic signed [W-1:0]   b_i,
    output logic signed [2*W-1:0] p_o
);
    // Sign-extend both operands to product width so nothing is truncated.
    assign p_o = (2*W)'(a_i) * (2*W)'(b_i);
endmodule

module mult_lut_arbiter #(
    parameter int MUT_WIDTH   = 6,
    parameter int NUM_REQ     = 4,
    parameter int CALC_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    mult_lut_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
    localparam int P_W   = 2 * MUT_WIDTH;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic        [ID_W-1:0]        ptr_q, ptr_d;
    logic signed [MUT_WIDTH-1:0]   op_a_q, op_a_d;
    logic signed [MUT_WIDTH-1:0]   op_b_q, op_b_d;
    logic        [CNT_W-1:0]       cnt_q, cnt_d;
    logic        [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic        [P_W-1:0]         res_q, res_d;
    logic        [ID_W-1:0]        res_id_q, res_id_d;

    logic                          win_vld;
    logic        [ID_W-1:0]        win_idx;
    logic signed [MUT_WIDTH-1:0]   win_a;
    logic signed [MUT_WIDTH-1:0]   win_b;
    logic signed [P_W-1:0]         prod;

    // The single shared LUT always sees the registered operands.
    mult_lut_signed #(.W(MUT_WIDTH)) u_lut (
        .a_i (op_a_q),
        .b_i (op_b_q),
        .p_o (prod)
    );

    // Round-robin pick: first set REQ bit after the last winner, wrapping around.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr_q;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!win_vld && bus.REQ[(int'(ptr_q) + off) % NUM_REQ]) begin
                win_vld = 1'b1;
                win_idx = ID_W'((int'(ptr_q) + off) % NUM_REQ);
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        win_a = bus.DATA_A[int'(win_idx)*MUT_WIDTH +: MUT_WIDTH];
        win_b = bus.DATA_B[int'(win_idx)*MUT_WIDTH +: MUT_WIDTH];
    end

    // Next-state and output decode; GNT and DONE are single-cycle pulses by default.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        cnt_d    = cnt_q;
        gnt_d    = '0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        res_d    = res_q;
        res_id_d = res_id_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    op_a_d  = win_a;
                    op_b_d  = win_b;
                    ptr_d   = win_idx;
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt_q == CNT_W'(CALC_CYCLES - 1)) begin
                    res_d    = prod;
                    res_id_d = ptr_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; reset aborts any operation and re-arms requester 0 as first winner.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            ptr_q    <= ID_W'(NUM_REQ - 1);
            op_a_q   <= '0;
            op_b_q   <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= '0;
            res_id_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            res_q    <= res_d;
            res_id_q <= res_id_d;
        end
    end

    assign bus.GNT    = gnt_q;
    assign bus.BUSY   = busy_q;
    assign bus.DATA_Q = res_q;
    assign bus.Q_ID   = res_id_q;
    assign bus.DONE   = done_q;
endmodule

// File: tb/tb_mult_lut_arbiter.sv
// Purpose: directed check of the shared multiplier arbiter (reset, grant order, products, abort).
// Latency: outputs sampled on the falling edge, one clock after the inputs were applied.
// Backpressure: requesters drop or keep REQ right after seeing their grant.
module tb_mult_lut_arbiter;
    logic CLK;
    logic RST;
    int   checks;
    int   failures;

    mult_lut_arbiter_if #(.MUT_WIDTH(6), .NUM_REQ(4)) bus ();

    mult_lut_arbiter #(.MUT_WIDTH(6), .NUM_REQ(4), .CALC_CYCLES(1)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input int a, input int b);
        bus.DATA_A[i*6 +: 6] = 6'(a);
        bus.DATA_B[i*6 +: 6] = 6'(b);
    endtask

    int         order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int         opa   [4] = '{3, -5, 7, -32};
    int         opb   [4] = '{4, 6, -8, 31};
    logic [11:0] prd  [4] = '{12'h00C, 12'hFE2, 12'hFC8, 12'hC20};
    logic [11:0] e;

    initial begin
        checks     = 0;
        failures   = 0;
        RST        = 1'b1;
        bus.REQ    = '0;
        bus.DATA_A = '0;
        bus.DATA_B = '0;

        // Reset state.
        #12;
        chk("rst_gnt",    32'(bus.GNT),    32'd0);
        chk("rst_busy",   32'(bus.BUSY),   32'd0);
        chk("rst_done",   32'(bus.DONE),   32'd0);
        chk("rst_dataq",  32'(bus.DATA_Q), 32'd0);
        chk("rst_qid",    32'(bus.Q_ID),   32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Single request from requester 2: -32 * -32 = 1024.
        set_op(2, -32, -32);
        bus.REQ = 4'b0100;
        @(negedge CLK);
        chk("t2_gnt",  32'(bus.GNT),  32'h4);
        chk("t2_busy", 32'(bus.BUSY), 32'd1);
        chk("t2_done0", 32'(bus.DONE), 32'd0);
        bus.REQ = 4'b0000;
        set_op(2, 0, 0);
        @(negedge CLK);
        chk("t2_done",  32'(bus.DONE),   32'd1);
        chk("t2_dataq", 32'(bus.DATA_Q), 32'h400);
        chk("t2_qid",   32'(bus.Q_ID),   32'd2);
        chk("t2_gnt0",  32'(bus.GNT),    32'd0);
        chk("t2_busy0", 32'(bus.BUSY),   32'd0);
        @(negedge CLK);
        chk("t2_pulse", 32'(bus.DONE),   32'd0);
        chk("t2_hold",  32'(bus.DATA_Q), 32'h400);
        chk("t2_idle_gnt", 32'(bus.GNT), 32'd0);

        // Reset in the middle of an operation for requester 1.
        set_op(1, 5, 7);
        bus.REQ = 4'b0010;
        @(negedge CLK);
        chk("t6_gnt",  32'(bus.GNT),  32'h2);
        chk("t6_busy", 32'(bus.BUSY), 32'd1);
        RST = 1'b1;
        #1;
        chk("t1_gnt",   32'(bus.GNT),    32'd0);
        chk("t1_busy",  32'(bus.BUSY),   32'd0);
        chk("t1_done",  32'(bus.DONE),   32'd0);
        chk("t1_dataq", 32'(bus.DATA_Q), 32'd0);
        chk("t1_qid",   32'(bus.Q_ID),   32'd0);
        bus.REQ = 4'b0000;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("t6_nodone",  32'(bus.DONE),   32'd0);
        chk("t6_nodataq", 32'(bus.DATA_Q), 32'd0);

        // All four requesting: pointer was reset, so order starts at 0.
        for (int i = 0; i < 4; i++) set_op(i, opa[i], opb[i]);
        bus.REQ = 4'b1111;
        for (int op = 0; op < 8; op++) begin
            @(negedge CLK);
            chk("t3_gnt",   32'(bus.GNT),  32'(1) << order[op]);
            chk("t3_done0", 32'(bus.DONE), 32'd0);
            if (op == 7) bus.REQ = 4'b0000;
            @(negedge CLK);
            chk("t3_done",  32'(bus.DONE),   32'd1);
            chk("t3_gnt0",  32'(bus.GNT),    32'd0);
            chk("t3_qid",   32'(bus.Q_ID),   32'(order[op]));
            chk("t3_dataq", 32'(bus.DATA_Q), 32'(prd[order[op]]));
        end

        // Requester 0 busy, then 3 and 0 both request: 3 wins before 0.
        set_op(0, -1, -1);
        bus.REQ = 4'b0001;
        @(negedge CLK);
        chk("t5_gnt0", 32'(bus.GNT), 32'h1);
        bus.REQ = 4'b1001;
        set_op(3, 31, -32);
        @(negedge CLK);
        chk("t5_done0", 32'(bus.DONE),   32'd1);
        chk("t5_qid0",  32'(bus.Q_ID),   32'd0);
        chk("t5_prod0", 32'(bus.DATA_Q), 32'h001);
        @(negedge CLK);
        chk("t5_gnt3", 32'(bus.GNT), 32'h8);
        bus.REQ = 4'b0001;
        @(negedge CLK);
        chk("t5_qid3",  32'(bus.Q_ID),   32'd3);
        chk("t5_prod3", 32'(bus.DATA_Q), 32'hC20);
        @(negedge CLK);
        chk("t5_gnt0b", 32'(bus.GNT), 32'h1);
        bus.REQ = 4'b0000;
        @(negedge CLK);
        chk("t5_qid0b", 32'(bus.Q_ID), 32'd0);

        // Requester 1 sweeps every operand pair, back to back.
        bus.REQ = 4'b0010;
        for (int a = -32; a < 32; a++) begin
            for (int b = -32; b < 32; b++) begin
                set_op(1, a, b);
                @(negedge CLK);
                chk("t4_gnt", 32'(bus.GNT), 32'h2);
                @(negedge CLK);
                e = 12'(a * b);
                chk("t4_prod", 32'(bus.DATA_Q), 32'(e));
            end
        end
        chk("t4_qid", 32'(bus.Q_ID), 32'd1);
        bus.REQ = 4'b0000;
        @(negedge CLK);
        chk("end_done", 32'(bus.DONE), 32'd0);
        chk("end_busy", 32'(bus.BUSY), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
